// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues single-outstanding memory reads and
// buffers returned words in a small prefetch FIFO for the core.
module fetch_sequencer #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 ins_valid,
  output logic [WORD_SIZE-1:0] ins_data,
  output logic [WORD_SIZE-1:0] ins_pc,
  input  logic                 ins_ready,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic                 busy_q;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WORD_SIZE-1:0] data_q [DEPTH];
  logic [WORD_SIZE-1:0] pc_q   [DEPTH];

  logic ack_v, outstanding, push, pop, flush, issue;

  always_comb begin
    ack_v       = mem_ack && mem_req_q;
    outstanding = mem_req_q && !mem_ack;
    ins_valid   = (count_q != '0) && !redirect_valid;
    pop         = ins_valid && ins_ready;
    push        = ack_v && !redirect_valid && (state_q == FETCH);
    flush       = redirect_valid && (state_q != IDLE);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid)   fetch_pc_d = redirect_pc;
        else if (start)       state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = outstanding ? DRAIN : FETCH;
        end else begin
          if (push)                 fetch_pc_d = fetch_pc_q + 1'b1;
          if (halt && !outstanding) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (!outstanding)   state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // Issue decision uses post-update occupancy so a request can follow an ack or a pop directly.
    issue      = (state_d == FETCH) && !outstanding && !halt && (count_d < CW'(DEPTH));
    mem_req_d  = outstanding || issue;
    mem_addr_d = issue ? fetch_pc_d : mem_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= (state_d != IDLE);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign ins_data = data_q[rd_ptr_q];
  assign ins_pc   = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expected values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt, redirect_valid, mem_ack, ins_ready;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, ins_valid, busy;
  logic [31:0] mem_addr, ins_data, ins_pc;
  logic        auto_ack;
  int          n_assert = 0;
  int          n_fail   = 0;

  fetch_sequencer #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
    .ins_ready(ins_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    if (auto_ack) begin
      mem_ack   = mem_req;
      mem_rdata = mem_addr + 32'h100;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0; ins_ready = 1'b0; auto_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_ins_data",  ins_data,       32'h0);
    chk("rst_ins_pc",    ins_pc,         32'h0);
    rst = 1'b0;

    // Streaming fetch with immediate acks and a ready consumer
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_req",  32'(mem_req), 32'h1);
    chk("start_addr", mem_addr,     32'h0);
    chk("start_busy", 32'(busy),    32'h1);
    ins_ready = 1'b1; auto_ack = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", 32'(ins_valid), 32'h1);
      chk("stream_pc",    ins_pc,         32'(i));
      chk("stream_data",  ins_data,       32'h100 + 32'(i));
      tick();
    end

    // Buffer fill with stalled consumer
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0; auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("full_req0", 32'(mem_req), 32'h0);
    tick();
    tick();
    chk("full_req1",  32'(mem_req), 32'h0);
    chk("full_pc",    ins_pc,       32'h0);
    chk("full_data",  ins_data,     32'h100);
    ins_ready = 1'b1;
    tick();
    chk("refill_req",  32'(mem_req), 32'h1);
    chk("refill_addr", mem_addr,     32'h4);
    chk("refill_pc",   ins_pc,       32'h1);
    tick();
    chk("order_pc2", ins_pc, 32'h2);
    tick();
    chk("order_pc3", ins_pc, 32'h3);
    tick();
    chk("order_pc4",   ins_pc,   32'h4);
    chk("order_data4", ins_data, 32'h104);

    // Redirect while a read is outstanding
    do_reset();
    ins_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    auto_ack = 1'b0; mem_ack = 1'b0;
    chk("pre_redir_addr", mem_addr, 32'h5);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_valid_mask", 32'(ins_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drain_req",   32'(mem_req),   32'h1);
    chk("drain_addr",  mem_addr,       32'h5);
    chk("drain_valid", 32'(ins_valid), 32'h0);
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("post_drain_req",   32'(mem_req),   32'h1);
    chk("post_drain_addr",  mem_addr,       32'h40);
    chk("post_drain_valid", 32'(ins_valid), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h140;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("redir_first_valid", 32'(ins_valid), 32'h1);
    chk("redir_first_pc",    ins_pc,         32'h40);
    chk("redir_first_data",  ins_data,       32'h140);

    // Redirect coincident with ack
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h20; mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    redirect_valid = 1'b0; mem_ack = 1'b0;
    #1;
    chk("redir_ack_req",   32'(mem_req),   32'h1);
    chk("redir_ack_addr",  mem_addr,       32'h20);
    chk("redir_ack_valid", 32'(ins_valid), 32'h0);

    // Redirect in IDLE to the top address, then wrap
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_busy", 32'(busy),    32'h0);
    chk("idle_redir_req",  32'(mem_req), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFF);
    ins_ready = 1'b1; auto_ack = 1'b1;
    tick();
    chk("wrap_pc0",   ins_pc,   32'hFFFF_FFFF);
    chk("wrap_data0", ins_data, 32'h0000_00FF);
    chk("wrap_addr1", mem_addr, 32'h0);
    tick();
    chk("wrap_pc1",   ins_pc,   32'h0);
    chk("wrap_data1", ins_data, 32'h100);

    // Halt with a pending read, then reset mid-read
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0; halt = 1'b1;
    tick();
    chk("halt_hold_req",  32'(mem_req), 32'h1);
    chk("halt_hold_busy", 32'(busy),    32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("halt_busy",  32'(busy),      32'h0);
    chk("halt_req",   32'(mem_req),   32'h0);
    chk("halt_valid", 32'(ins_valid), 32'h1);
    chk("halt_pc",    ins_pc,         32'h0);
    chk("halt_data",  ins_data,       32'h55);
    tick();
    chk("halt_req_later",   32'(mem_req),   32'h0);
    chk("halt_buffer_kept", 32'(ins_valid), 32'h1);
    halt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rest_req",  32'(mem_req), 32'h1);
    chk("rest_addr", mem_addr,     32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req",   32'(mem_req),   32'h0);
    chk("async_rst_addr",  mem_addr,       32'h0);
    chk("async_rst_valid", 32'(ins_valid), 32'h0);
    chk("async_rst_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBEEF;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_valid", 32'(ins_valid), 32'h0);
    chk("late_ack_req",   32'(mem_req),   32'h0);
    chk("late_ack_busy",  32'(busy),      32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
